// File: rtl/fetch_pc_unit_pkg.sv
// Shared definitions for the fetch/PC stage: control-flow opcodes (also used
// by decode and the branch comparator) and the fetch FSM state encoding.
package fetch_pc_unit_pkg;

    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        WAIT  = 3'd2,
        HOLD  = 3'd3,
        TRAP  = 3'd4
    } state_t;

endpackage

// File: rtl/fetch_pc_unit_next_pc_calc.sv
// Combinational next-PC selection: JAL, JALR, taken conditional branch,
// otherwise sequential pc+4. All sums wrap modulo 2^XLEN.
module fetch_pc_unit_next_pc_calc
    import fetch_pc_unit_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] pc,
    input  logic [6:0]      opcode,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] rs1_data,
    input  logic            branch,
    output logic [XLEN-1:0] next_pc
);

    localparam logic [XLEN-1:0] JALR_MASK = {{(XLEN-1){1'b1}}, 1'b0};

    // Target select; a taken flag on a non-branch opcode falls through to pc+4
    always_comb begin
        next_pc = pc + XLEN'(4);
        case (opcode)
            OP_JAL:    next_pc = pc + imm;
            OP_JALR:   next_pc = (rs1_data + imm) & JALR_MASK;
            OP_BRANCH: if (branch) next_pc = pc + imm;
            default:   next_pc = pc + XLEN'(4);
        endcase
    end

endmodule

// File: rtl/fetch_pc_unit.sv
// Program counter and instruction fetch stage. Fetches one instruction per
// retire over a req/gnt/rvalid handshake and holds it for decode.
// Optional feature macro: MISALIGN_TRAP_EN -- a misaligned next PC parks the
// unit in TRAP (until reset) instead of silently clearing the low PC bits.
module fetch_pc_unit
    import fetch_pc_unit_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            branch,
    input  logic [6:0]      opcode,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] rs1_data,
    input  logic            retire,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    output logic [XLEN-1:0] instr_o,
    output logic            instr_valid_o,
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] pc_plus4_o,
    output logic            misalign_o
);

    state_t          state, state_d;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] next_pc;
    logic [XLEN-1:0] pc_target;
    logic            pc_load;
    logic            capture;

    fetch_pc_unit_next_pc_calc #(.XLEN(XLEN)) u_next_pc_calc (
        .pc       (pc),
        .opcode   (opcode),
        .imm      (imm),
        .rs1_data (rs1_data),
        .branch   (branch),
        .next_pc  (next_pc)
    );

`ifdef MISALIGN_TRAP_EN
    // Trap path keeps the offending address visible on pc_o
    assign pc_target  = next_pc;
    assign misalign_o = (state == TRAP);
`else
    // Without the trap the PC is kept word aligned by dropping the low bits
    assign pc_target  = next_pc & {{(XLEN-2){1'b1}}, 2'b00};
    assign misalign_o = 1'b0;
`endif

    assign imem_addr     = pc;
    assign pc_o          = pc;
    assign pc_plus4_o    = pc + XLEN'(4);
    assign instr_valid_o = (state == HOLD);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_d;
    end

    // Next-state and handshake control; stray gnt/rvalid/retire fall through
    always_comb begin
        state_d  = state;
        imem_req = 1'b0;
        pc_load  = 1'b0;
        capture  = 1'b0;
        case (state)
            IDLE: state_d = FETCH;
            FETCH: begin
                imem_req = 1'b1;
                if (imem_gnt) begin
                    if (imem_rvalid) begin
                        capture = 1'b1;
                        state_d = HOLD;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (imem_rvalid) begin
                    capture = 1'b1;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (retire) begin
                    pc_load = 1'b1;
`ifdef MISALIGN_TRAP_EN
                    state_d = (next_pc[1:0] != 2'b00) ? TRAP : FETCH;
`else
                    state_d = FETCH;
`endif
                end
            end
            TRAP:    state_d = TRAP;
            default: state_d = IDLE;
        endcase
    end

    // PC and held-instruction registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc      <= RESET_PC;
            instr_o <= '0;
        end else begin
            if (pc_load) pc      <= pc_target;
            if (capture) instr_o <= imem_rdata;
        end
    end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed self-checking bench for fetch_pc_unit. Inputs are driven and
// outputs sampled on the falling clock edge.
module tb_fetch_pc_unit;
    import fetch_pc_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        branch;
    logic [6:0]  opcode;
    logic [31:0] imm, rs1_data;
    logic        retire;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt, imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] instr_o;
    logic        instr_valid_o;
    logic [31:0] pc_o, pc_plus4_o;
    logic        misalign_o;

    int checks = 0;
    int errors = 0;

    localparam logic [6:0] OP_ADDI = 7'b0010011;

    always #5 clk = ~clk;

    fetch_pc_unit dut (
        .clk(clk), .rst_n(rst_n), .branch(branch), .opcode(opcode), .imm(imm),
        .rs1_data(rs1_data), .retire(retire), .imem_req(imem_req),
        .imem_addr(imem_addr), .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid),
        .imem_rdata(imem_rdata), .instr_o(instr_o), .instr_valid_o(instr_valid_o),
        .pc_o(pc_o), .pc_plus4_o(pc_plus4_o), .misalign_o(misalign_o)
    );

    // Stimulus: answer the pending fetch and leave the unit in HOLD at a negedge
    task automatic serve(input logic [31:0] data, input bit zero_lat);
        int n = 0;
        while (!imem_req && n < 20) begin @(negedge clk); n++; end
        checks++;
        if (!imem_req) begin errors++; $display("FAIL serve_req_timeout got req=%b want 1", imem_req); end
        imem_gnt = 1'b1; imem_rvalid = zero_lat; imem_rdata = data;
        @(negedge clk);
        imem_gnt = 1'b0; imem_rvalid = 1'b0;
        if (!zero_lat) begin
            imem_rvalid = 1'b1;
            @(negedge clk);
            imem_rvalid = 1'b0;
        end
        n = 0;
        while (!instr_valid_o && n < 20) begin @(negedge clk); n++; end
        checks++;
        if (!instr_valid_o) begin errors++; $display("FAIL serve_valid_timeout got valid=%b want 1", instr_valid_o); end
    endtask

    // Stimulus: retire the held instruction with the given control-flow info
    task automatic do_retire(input logic [6:0] op, input logic [31:0] im,
                             input logic [31:0] rs1, input logic br);
        opcode = op; imm = im; rs1_data = rs1; branch = br; retire = 1'b1;
        @(negedge clk);
        retire = 1'b0; branch = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; branch = 0; opcode = 0; imm = 0; rs1_data = 0; retire = 0;
        imem_gnt = 0; imem_rvalid = 0; imem_rdata = 0;
        repeat (3) @(negedge clk);
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rst_req got %b want 0", imem_req); end
        checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL rst_addr got %h want 0", imem_addr); end
        checks++; if (instr_o !== 32'h0) begin errors++; $display("FAIL rst_instr got %h want 0", instr_o); end
        checks++; if (instr_valid_o !== 1'b0) begin errors++; $display("FAIL rst_valid got %b want 0", instr_valid_o); end
        checks++; if (misalign_o !== 1'b0) begin errors++; $display("FAIL rst_misalign got %b want 0", misalign_o); end
        rst_n = 1'b1;
        // Still IDLE during the first cycle after release
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL idle_req got %b want 0", imem_req); end
    endtask

    task automatic test_basic_fetch;
        @(negedge clk);
        checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL fetch_req got %b want 1", imem_req); end
        checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL fetch_addr got %h want 0", imem_addr); end
        imem_gnt = 1'b1;
        @(negedge clk);
        imem_gnt = 1'b0;
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL wait_req got %b want 0", imem_req); end
        imem_rvalid = 1'b1; imem_rdata = 32'h0000_0013;
        @(negedge clk);
        imem_rvalid = 1'b0;
        checks++; if (instr_valid_o !== 1'b1) begin errors++; $display("FAIL hold_valid got %b want 1", instr_valid_o); end
        checks++; if (instr_o !== 32'h13) begin errors++; $display("FAIL hold_instr got %h want 13", instr_o); end
        checks++; if (pc_o !== 32'h0) begin errors++; $display("FAIL hold_pc got %h want 0", pc_o); end
        checks++; if (pc_plus4_o !== 32'h4) begin errors++; $display("FAIL hold_pc4 got %h want 4", pc_plus4_o); end
        do_retire(OP_ADDI, 32'h0, 32'h0, 1'b0);
        checks++; if (instr_valid_o !== 1'b0) begin errors++; $display("FAIL retire_valid got %b want 0", instr_valid_o); end
        checks++; if (imem_addr !== 32'h4) begin errors++; $display("FAIL seq_addr got %h want 4", imem_addr); end
    endtask

    task automatic test_branch;
        serve(32'h0fc0_006f, 1'b0);
        do_retire(OP_JAL, 32'h0000_00fc, 32'h0, 1'b0);            // 4 -> 0x100
        checks++; if (imem_addr !== 32'h100) begin errors++; $display("FAIL jal_to_100 got %h want 100", imem_addr); end
        serve(32'h0000_0063, 1'b0);
        do_retire(OP_BRANCH, 32'hffff_fff8, 32'h0, 1'b1);         // taken, -8
        checks++; if (imem_addr !== 32'h0f8) begin errors++; $display("FAIL br_taken got %h want 0f8", imem_addr); end
        serve(32'h0080_006f, 1'b0);
        do_retire(OP_JAL, 32'h0000_0008, 32'h0, 1'b0);            // 0xf8 -> 0x100
        serve(32'h0000_0063, 1'b0);
        do_retire(OP_BRANCH, 32'hffff_fff8, 32'h0, 1'b0);         // not taken
        checks++; if (imem_addr !== 32'h104) begin errors++; $display("FAIL br_not_taken got %h want 104", imem_addr); end
        serve(32'h0000_0013, 1'b0);
        do_retire(OP_ADDI, 32'hffff_fff8, 32'h0, 1'b1);           // stray taken flag
        checks++; if (imem_addr !== 32'h108) begin errors++; $display("FAIL br_nonbranch got %h want 108", imem_addr); end
    endtask

    task automatic test_jump;
        serve(32'h0000_0067, 1'b0);
        do_retire(OP_JALR, 32'h4, 32'h2001, 1'b0);                // (0x2005)&~1
        checks++; if (imem_addr !== 32'h2004) begin errors++; $display("FAIL jalr got %h want 2004", imem_addr); end
        serve(32'h0000_006f, 1'b0);
        do_retire(OP_JAL, 32'hffff_dff8, 32'h0, 1'b0);            // 0x2004 -> 0xfffffffc
        checks++; if (imem_addr !== 32'hffff_fffc) begin errors++; $display("FAIL jal_top got %h want fffffffc", imem_addr); end
        serve(32'h0080_006f, 1'b0);
        checks++; if (pc_plus4_o !== 32'h0) begin errors++; $display("FAIL pc4_wrap got %h want 0", pc_plus4_o); end
        do_retire(OP_JAL, 32'h8, 32'h0, 1'b0);
        checks++; if (imem_addr !== 32'h4) begin errors++; $display("FAIL jal_wrap got %h want 4", imem_addr); end
    endtask

    task automatic test_stall_zero_latency;
        // Retire while fetching must not move the PC
        opcode = OP_JAL; imm = 32'h100; retire = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL stall_req[%0d] got %b want 1", i, imem_req); end
            checks++; if (imem_addr !== 32'h4) begin errors++; $display("FAIL stall_addr[%0d] got %h want 4", i, imem_addr); end
        end
        retire = 1'b0;
        imem_gnt = 1'b1; imem_rvalid = 1'b1; imem_rdata = 32'h0000_00aa;
        @(negedge clk);
        imem_gnt = 1'b0; imem_rvalid = 1'b0;
        checks++; if (instr_valid_o !== 1'b1) begin errors++; $display("FAIL zl_valid got %b want 1", instr_valid_o); end
        checks++; if (instr_o !== 32'haa) begin errors++; $display("FAIL zl_instr got %h want aa", instr_o); end
        checks++; if (pc_o !== 32'h4) begin errors++; $display("FAIL zl_pc got %h want 4", pc_o); end
        do_retire(OP_ADDI, 32'h0, 32'h0, 1'b0);
        checks++; if (imem_addr !== 32'h8) begin errors++; $display("FAIL zl_next got %h want 8", imem_addr); end
    endtask

    task automatic test_async_reset;
        serve(32'h0380_006f, 1'b0);
        do_retire(OP_JAL, 32'h38, 32'h0, 1'b0);                   // 8 -> 0x40
        checks++; if (imem_addr !== 32'h40) begin errors++; $display("FAIL ar_addr got %h want 40", imem_addr); end
        imem_gnt = 1'b1;
        @(negedge clk);
        imem_gnt = 1'b0;                                          // now in WAIT
        #2 rst_n = 1'b0;
        #1;
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL ar_req got %b want 0", imem_req); end
        checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL ar_pc got %h want 0", imem_addr); end
        @(negedge clk);
        rst_n = 1'b1; imem_rvalid = 1'b1; imem_rdata = 32'hdead_beef;
        checks++; if (instr_valid_o !== 1'b0) begin errors++; $display("FAIL ar_idle_valid got %b want 0", instr_valid_o); end
        @(negedge clk);
        checks++; if (instr_valid_o !== 1'b0) begin errors++; $display("FAIL ar_stray_valid got %b want 0", instr_valid_o); end
        checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL ar_refetch_req got %b want 1", imem_req); end
        imem_rvalid = 1'b0;
        @(negedge clk);
        checks++; if (instr_valid_o !== 1'b0) begin errors++; $display("FAIL ar_after_valid got %b want 0", instr_valid_o); end
        checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL ar_refetch_addr got %h want 0", imem_addr); end
    endtask

    task automatic test_misalign;
        serve(32'h0060_006f, 1'b0);
        do_retire(OP_JAL, 32'h6, 32'h0, 1'b0);                    // 0 -> 6
`ifdef MISALIGN_TRAP_EN
        for (int i = 0; i < 3; i++) begin
            checks++; if (misalign_o !== 1'b1) begin errors++; $display("FAIL trap_misalign[%0d] got %b want 1", i, misalign_o); end
            checks++; if (pc_o !== 32'h6) begin errors++; $display("FAIL trap_pc[%0d] got %h want 6", i, pc_o); end
            checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL trap_req[%0d] got %b want 0", i, imem_req); end
            checks++; if (instr_valid_o !== 1'b0) begin errors++; $display("FAIL trap_valid[%0d] got %b want 0", i, instr_valid_o); end
            @(negedge clk);
        end
        rst_n = 1'b0;
        @(negedge clk);
        checks++; if (misalign_o !== 1'b0) begin errors++; $display("FAIL trap_rst got %b want 0", misalign_o); end
        rst_n = 1'b1;
`else
        checks++; if (imem_addr !== 32'h4) begin errors++; $display("FAIL mis_masked got %h want 4", imem_addr); end
        checks++; if (misalign_o !== 1'b0) begin errors++; $display("FAIL mis_flag got %b want 0", misalign_o); end
        checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL mis_req got %b want 1", imem_req); end
`endif
    endtask

    initial begin
        test_reset;
        test_basic_fetch;
        test_branch;
        test_jump;
        test_stall_zero_latency;
        test_async_reset;
        test_misalign;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
